// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: address/count widths and parameter legality.
// Used by fifo_multi_read (optional FIFO_ERR_FLAG_EN error flags) and fifo_mem.
package fifo_pkg;

    // Pointer width; a single-entry FIFO still needs a 1-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width, wide enough to hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int data_width, input int depth,
                                        input int num_read, input int af_thres,
                                        input int ae_thres);
        return (data_width >= 1) &&
               (depth >= 1) && ((depth & (depth - 1)) == 0) &&
               (num_read >= 1) && (num_read <= depth) && ((depth % num_read) == 0) &&
               (af_thres >= 0) && (af_thres <= depth) &&
               (ae_thres >= 0) && (ae_thres <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array FIFO storage: one write port and NUM_READ combinational read
// ports at consecutive addresses from rd_base, wrapping modulo DEPTH.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int NUM_READ   = 2,
    parameter int ADDR_W     = addr_width(DEPTH)
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [ADDR_W-1:0]              rd_base,
    output logic [DATA_WIDTH*NUM_READ-1:0] rd_data
);

    // Storage is deliberately not reset; validity is tracked by the pointers.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd_port
        logic [ADDR_W-1:0] rd_addr;
        // Pointer-width addition wraps on its own since DEPTH is a power of 2.
        assign rd_addr = rd_base + ADDR_W'(k);
        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr];
    end

endmodule

// File: rtl/fifo_multi_read.sv
// Show-ahead FIFO: one word in per write, NUM_READ oldest words out per read.
// Define FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module fifo_multi_read
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 8,
    parameter int NUM_READ           = 2,
    parameter int ALMOST_FULL_THRES  = 2,
    parameter int ALMOST_EMPTY_THRES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           wr_en,
    input  logic                           rd_en,
    output logic [DATA_WIDTH*NUM_READ-1:0] rd_data,
    output logic                           empty,
    output logic                           full,
    output logic                           almost_full,
    output logic                           almost_empty,
`ifdef FIFO_ERR_FLAG_EN
    output logic                           overflow,
    output logic                           underflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0]  NR_C     = CNT_W'(NUM_READ);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_LVL   = CNT_W'(DEPTH - ALMOST_FULL_THRES);
    localparam logic [CNT_W-1:0]  AE_LVL   = CNT_W'(ALMOST_EMPTY_THRES);
    localparam logic [CNT_W:0]    NR_X     = (CNT_W+1)'(NUM_READ);
    localparam logic [ADDR_W-1:0] RD_STEP  = ADDR_W'(NUM_READ);

    if (!params_legal(DATA_WIDTH, DEPTH, NUM_READ, ALMOST_FULL_THRES, ALMOST_EMPTY_THRES))
    begin : g_bad_params
        $error("fifo_multi_read: illegal parameter combination");
    end

    logic [ADDR_W-1:0]              wr_ptr;
    logic [ADDR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]               cnt_q;
    logic [CNT_W:0]                 cnt_nxt;
    logic                           cnt_nxt_msb_unused;
    logic                           wr_acc;
    logic                           rd_acc;
    logic [DATA_WIDTH*NUM_READ-1:0] mem_rd_data;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // One bit of headroom so the add/subtract never truncates mid-expression.
    always_comb begin
        cnt_nxt = {1'b0, cnt_q} + {{CNT_W{1'b0}}, wr_acc} - (rd_acc ? NR_X : '0);
    end
    assign cnt_nxt_msb_unused = cnt_nxt[CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + RD_STEP;
            end
            cnt_q <= cnt_nxt[CNT_W-1:0];
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .NUM_READ   (NUM_READ),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_base (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Flags come only from the registered count, never from wr_en/rd_en.
    assign count        = cnt_q;
    assign empty        = (cnt_q < NR_C);
    assign full         = (cnt_q == DEPTH_C);
    assign almost_full  = (cnt_q >= AF_LVL);
    assign almost_empty = (cnt_q <= AE_LVL);

    // Masking while empty gives rd_data = 0 out of reset without clearing storage.
    assign rd_data = empty ? '0 : mem_rd_data;

`ifdef FIFO_ERR_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_multi_read.sv
// Self-checking bench for fifo_multi_read against a queue-based reference model.
// Covers the optional FIFO_ERR_FLAG_EN outputs when that macro is defined.
module tb_fifo_multi_read;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int NR    = 2;
    localparam int AF    = 2;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     wr_data = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DW*NR-1:0]  rd_data;
    logic              empty, full, almost_full, almost_empty;
    logic [CW-1:0]     count;
`ifdef FIFO_ERR_FLAG_EN
    logic              overflow, underflow;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: words in arrival order plus sticky error state.
    logic [DW-1:0] q[$];
    bit            m_ov = 0;
    bit            m_uf = 0;

    always #5 clk = ~clk;

    fifo_multi_read #(
        .DATA_WIDTH         (DW),
        .DEPTH              (DEPTH),
        .NUM_READ           (NR),
        .ALMOST_FULL_THRES  (AF),
        .ALMOST_EMPTY_THRES (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAG_EN
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    // {empty, almost_empty, full, almost_full} as the model sees it.
    function automatic logic [3:0] exp_flags();
        int n = q.size();
        return {n < NR, n <= AE, n == DEPTH, n >= DEPTH - AF};
    endfunction

    function automatic logic [DW*NR-1:0] exp_rd();
        logic [DW*NR-1:0] v = '0;
        if (q.size() >= NR)
            for (int k = 0; k < NR; k++) v[k*DW +: DW] = q[k];
        return v;
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
        return CW'(q.size());
    endfunction

    // Drive one cycle, apply the model at the edge, leave time at edge + 1.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        bit wacc, racc;
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        wacc = w && (q.size() < DEPTH);
        racc = r && (q.size() >= NR);
        if (w && q.size() == DEPTH) m_ov = 1;
        if (r && q.size() < NR) m_uf = 1;
        if (racc) for (int k = 0; k < NR; k++) void'(q.pop_front());
        if (wacc) q.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            errors++; $display("FAIL reset_flags got %b exp 1100", {empty, almost_empty, full, almost_full}); end
        checks++; if (count !== '0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (rd_data !== '0) begin
            errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
`ifdef FIFO_ERR_FLAG_EN
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
`endif
        #2 rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b1);
        checks++; if (count !== exp_cnt()) begin
            errors++; $display("FAIL underrun_count got %0d exp %0d", count, exp_cnt()); end
        checks++; if (empty !== 1'b1) begin
            errors++; $display("FAIL underrun_empty got %b exp 1", empty); end
`ifdef FIFO_ERR_FLAG_EN
        checks++; if (underflow !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL underflow_flag got %b%b exp 01", overflow, underflow); end
`endif
    endtask

    task automatic test_pair();
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        checks++; if (count !== 4'd2 || empty !== 1'b0) begin
            errors++; $display("FAIL pair_count got %0d/%b exp 2/0", count, empty); end
        checks++; if (rd_data !== 16'h0201) begin
            errors++; $display("FAIL pair_rd_data got %h exp 0201", rd_data); end
        step(1'b0, '0, 1'b1);
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL pair_pop got %0d/%b exp 0/1", count, empty); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0);
            checks++; if ({almost_full, full} !== {i >= DEPTH - AF, 1'b0}) begin
                errors++; $display("FAIL fill_af_%0d got %b%b exp %b0", i, almost_full, full, i >= DEPTH - AF); end
        end
        step(1'b1, 8'h17, 1'b0);
        step(1'b1, 8'h18, 1'b0);
        checks++; if (full !== 1'b1 || count !== 4'd8) begin
            errors++; $display("FAIL fill_full got %b/%0d exp 1/8", full, count); end
        step(1'b1, 8'h19, 1'b0);
        checks++; if (count !== 4'd8 || rd_data !== 16'h1211) begin
            errors++; $display("FAIL fill_ignore got %0d/%h exp 8/1211", count, rd_data); end
`ifdef FIFO_ERR_FLAG_EN
        checks++; if (overflow !== 1'b1) begin
            errors++; $display("FAIL overflow_flag got %b exp 1", overflow); end
`endif
    endtask

    task automatic test_wrap();
        logic [15:0] want [4] = '{16'h1211, 16'h1413, 16'h1615, 16'h1817};
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data !== want[i]) begin
                errors++; $display("FAIL wrap_rd_%0d got %h exp %h", i, rd_data, want[i]); end
            step(1'b0, '0, 1'b1);
        end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin
            errors++; $display("FAIL wrap_drained got %b/%0d exp 1/0", empty, count); end
        step(1'b1, 8'hA1, 1'b0);
        step(1'b1, 8'hA2, 1'b0);
        step(1'b1, 8'hA3, 1'b0);
        checks++; if (rd_data !== 16'hA2A1 || count !== 4'd3) begin
            errors++; $display("FAIL wrap_refill got %h/%0d exp a2a1/3", rd_data, count); end
    endtask

    task automatic test_simul();
        step(1'b1, 8'hA4, 1'b0);
        checks++; if (count !== 4'd4) begin
            errors++; $display("FAIL simul_pre got %0d exp 4", count); end
        step(1'b1, 8'h55, 1'b1);
        checks++; if (count !== 4'd3 || rd_data !== 16'hA4A3) begin
            errors++; $display("FAIL simul_both got %0d/%h exp 3/a4a3", count, rd_data); end
        step(1'b1, 8'h56, 1'b1);
        checks++; if (rd_data !== 16'h5655 || count !== exp_cnt()) begin
            errors++; $display("FAIL simul_order got %h/%0d exp 5655/%0d", rd_data, count, exp_cnt()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int bias = ((i / 50) % 2 == 0) ? 75 : 30;
            step($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) < 100 - bias);
            checks++; if (count !== exp_cnt()) begin
                errors++; $display("FAIL rand_count_%0d got %0d exp %0d", i, count, exp_cnt()); end
            checks++; if ({empty, almost_empty, full, almost_full} !== exp_flags()) begin
                errors++; $display("FAIL rand_flags_%0d got %b exp %b", i, {empty, almost_empty, full, almost_full}, exp_flags()); end
            checks++; if (rd_data !== exp_rd()) begin
                errors++; $display("FAIL rand_rd_%0d got %h exp %h", i, rd_data, exp_rd()); end
`ifdef FIFO_ERR_FLAG_EN
            checks++; if ({overflow, underflow} !== {m_ov, m_uf}) begin
                errors++; $display("FAIL rand_err_%0d got %b%b exp %b%b", i, overflow, underflow, m_ov, m_uf); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        while (q.size() > 5) step(1'b0, '0, 1'b1);
        while (q.size() < 5) step(1'b1, 8'($urandom), 1'b0);
        checks++; if (count !== 4'd5) begin
            errors++; $display("FAIL mid_pre got %0d exp 5", count); end
        #2 rst_n = 1'b0;
        #1;
        q.delete(); m_ov = 0; m_uf = 0;
        checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100 || count !== '0) begin
            errors++; $display("FAIL mid_async got %b/%0d exp 1100/0", {empty, almost_empty, full, almost_full}, count); end
        checks++; if (rd_data !== '0) begin
            errors++; $display("FAIL mid_rd_data got %h exp 0", rd_data); end
`ifdef FIFO_ERR_FLAG_EN
        checks++; if ({overflow, underflow} !== 2'b00) begin
            errors++; $display("FAIL mid_err got %b%b exp 00", overflow, underflow); end
`endif
        #3 rst_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h4D, 1'b0);
        checks++; if (count !== 4'd2 || rd_data !== 16'h4D3C) begin
            errors++; $display("FAIL mid_restart got %0d/%h exp 2/4d3c", count, rd_data); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_fill();
        test_wrap();
        test_simul();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
